// File: rtl/muldiv_pkg.sv
// Shared types and constants for the sequential RV32M multiply/divide unit.
// Holds the FSM state encoding and the funct3 opcode values.
package muldiv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the pipeline and the multiply/divide unit.
// The pipeline side is the master; the arithmetic unit is the slave.
interface muldiv_seq_if;
    import muldiv_pkg::*;

    logic            start_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] a_i;
    logic [XLEN-1:0] b_i;
    logic            busy_o;
    logic            stall_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output start_i, funct3_i, a_i, b_i,
        input  busy_o, stall_o, done_o, result_o
    );

    modport slave (
        input  start_i, funct3_i, a_i, b_i,
        output busy_o, stall_o, done_o, result_o
    );

endinterface

// File: rtl/muldiv_seq.sv
// Sequential RV32M unit: 32-step shift-add multiply and restoring divide
// sharing one 64-bit accumulator, with sign fix-up in a final cycle.
module muldiv_seq
    import muldiv_pkg::*;
(
    input logic        clk_i,
    input logic        rst_i,
    muldiv_seq_if.slave bus
);

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   mb_q, mb_d;
    logic              neg_q, neg_d;
    logic              negr_q, negr_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   res_q, res_d;

    logic            sa, sb, is_div;
    logic [XLEN-1:0] abs_a, abs_b;
    logic [XLEN:0]   sum;
    logic [XLEN-1:0] diff;
    logic            ge;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0] quo, rem;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            op_q    <= '0;
            mb_q    <= '0;
            neg_q   <= 1'b0;
            negr_q  <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            mb_q    <= mb_d;
            neg_q   <= neg_d;
            negr_q  <= negr_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        mb_d    = mb_q;
        neg_d   = neg_q;
        negr_d  = negr_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        res_d   = res_q;

        is_div = bus.funct3_i[2];
        sa = bus.a_i[XLEN-1] &
             (bus.funct3_i == OP_MULH || bus.funct3_i == OP_MULHSU ||
              bus.funct3_i == OP_DIV  || bus.funct3_i == OP_REM);
        sb = bus.b_i[XLEN-1] &
             (bus.funct3_i == OP_MULH || bus.funct3_i == OP_DIV ||
              bus.funct3_i == OP_REM);
        abs_a = sa ? -bus.a_i : bus.a_i;
        abs_b = sb ? -bus.b_i : bus.b_i;

        // Multiply: add to the high half when the LSB is set, then shift right.
        sum = {1'b0, acc_q[2*XLEN-1:XLEN]} +
              {1'b0, (acc_q[0] ? mb_q : '0)};
        // Divide: the shifted partial remainder needs XLEN+1 bits.
        ge   = acc_q[2*XLEN-1:XLEN-1] >= {1'b0, mb_q};
        diff = acc_q[2*XLEN-2:XLEN-1] - mb_q;

        prod = neg_q ? (~acc_q + 64'd1) : acc_q;
        quo  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem  = negr_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

        unique case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    if (is_div && bus.b_i == '0) begin
                        res_d   = bus.funct3_i[1] ? bus.a_i : '1;
                        state_d = DONE;
                    end else begin
                        op_d    = bus.funct3_i;
                        mb_d    = abs_b;
                        neg_d   = sa ^ sb;
                        negr_d  = sa;
                        acc_d   = {{XLEN{1'b0}}, abs_a};
                        cnt_d   = 5'd31;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (op_q[2])
                    acc_d = {(ge ? diff : acc_q[2*XLEN-2:XLEN-1]),
                             acc_q[XLEN-2:0], ge};
                else
                    acc_d = {sum, acc_q[XLEN-1:1]};
                if (cnt_q == 5'd0)
                    state_d = FIX;
                else
                    cnt_d = cnt_q - 5'd1;
            end
            FIX: begin
                if (op_q[2])
                    res_d = op_q[1] ? rem : quo;
                else if (op_q == OP_MUL)
                    res_d = prod[XLEN-1:0];
                else
                    res_d = prod[2*XLEN-1:XLEN];
                state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy_o   = state_q != IDLE;
    assign bus.stall_o  = (state_q == IDLE && bus.start_i) ||
                          state_q == CALC || state_q == FIX;
    assign bus.done_o   = state_q == DONE;
    assign bus.result_o = res_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq: opcode vectors, latency,
// stall/busy profile, ignored restart, and reset abort.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   asserts = 0;
    int   fails = 0;

    muldiv_seq_if bus ();

    muldiv_seq dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Issue one op; check stall/busy each cycle, done latency and result.
    task automatic run_op(input vec_t v, input int pulse);
        int  n;
        bit  got;
        @(negedge clk);
        bus.start_i  = 1'b1;
        bus.funct3_i = v.f;
        bus.a_i      = v.a;
        bus.b_i      = v.b;
        #1;
        chk({v.nm, " stall c0"}, 32'(bus.stall_o), 32'd1);
        chk({v.nm, " busy c0"}, 32'(bus.busy_o), 32'd0);
        n = 0;
        got = 1'b0;
        while (n < 60 && !got) begin
            @(negedge clk);
            n++;
            bus.start_i  = (n == pulse);
            bus.funct3_i = 3'($urandom);
            bus.a_i      = $urandom;
            bus.b_i      = $urandom;
            #1;
            if (bus.done_o) got = 1'b1;
            if (n < v.lat)
                chk({v.nm, " stall"}, 32'(bus.stall_o), 32'd1);
            chk({v.nm, " busy"}, 32'(bus.busy_o), 32'(n <= v.lat));
        end
        bus.start_i = 1'b0;
        chk({v.nm, " latency"}, 32'(n), 32'(v.lat));
        chk({v.nm, " stall at done"}, 32'(bus.stall_o), 32'd0);
        chk({v.nm, " result"}, bus.result_o, v.exp);
        @(negedge clk);
        #1;
        chk({v.nm, " done pulse"}, 32'(bus.done_o), 32'd0);
        chk({v.nm, " held"}, bus.result_o, v.exp);
    endtask

    vec_t vt[$];
    vec_t v;
    int   n;
    bit   seen;

    initial begin
        vt.push_back('{"mul", OP_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 34});
        vt.push_back('{"mulh", OP_MULH, 32'h80000000, 32'h80000000, 32'h40000000, 34});
        vt.push_back('{"mulh neg", OP_MULH, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 34});
        vt.push_back('{"mulhu", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34});
        vt.push_back('{"mulhu 2^32", OP_MULHU, 32'h10000, 32'h10000, 32'd1, 34});
        vt.push_back('{"mulhsu", OP_MULHSU, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 34});
        vt.push_back('{"mulhsu ub", OP_MULHSU, 32'd2, 32'hFFFFFFFF, 32'd1, 34});
        vt.push_back('{"div", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34});
        vt.push_back('{"rem", OP_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34});
        vt.push_back('{"div negb", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 34});
        vt.push_back('{"rem negb", OP_REM, 32'd7, 32'hFFFFFFFE, 32'd1, 34});
        vt.push_back('{"div ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34});
        vt.push_back('{"rem ovf", OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, 34});
        vt.push_back('{"divu", OP_DIVU, 32'd100, 32'd7, 32'd14, 34});
        vt.push_back('{"remu", OP_REMU, 32'd100, 32'd7, 32'd2, 34});
        vt.push_back('{"divu by0", OP_DIVU, 32'd100, 32'd0, 32'hFFFFFFFF, 1});
        vt.push_back('{"remu by0", OP_REMU, 32'd100, 32'd0, 32'd100, 1});
        vt.push_back('{"div by0", OP_DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 1});
        vt.push_back('{"rem by0", OP_REM, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 1});

        // Reset with start held high: start must be dropped.
        bus.start_i  = 1'b1;
        bus.funct3_i = OP_MUL;
        bus.a_i      = 32'd3;
        bus.b_i      = 32'd5;
        repeat (2) @(negedge clk);
        #1;
        chk("rst busy", 32'(bus.busy_o), 32'd0);
        chk("rst done", 32'(bus.done_o), 32'd0);
        chk("rst result", bus.result_o, 32'd0);
        chk("rst stall=start", 32'(bus.stall_o), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        bus.start_i = 1'b0;
        #1;
        chk("rst stall idle", 32'(bus.stall_o), 32'd0);

        foreach (vt[i]) run_op(vt[i], -1);

        // A second start during CALC must not disturb the running divide.
        v = '{"restart ignored", OP_DIVU, 32'd100, 32'd7, 32'd14, 34};
        run_op(v, 5);

        // Reset in cycle 10 of a multiply aborts it without a done pulse.
        @(negedge clk);
        bus.start_i  = 1'b1;
        bus.funct3_i = OP_MUL;
        bus.a_i      = 32'd9;
        bus.b_i      = 32'd9;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            bus.start_i = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort busy", 32'(bus.busy_o), 32'd0);
        chk("abort result", bus.result_o, 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.done_o) seen = 1'b1;
        end
        chk("abort no done", 32'(seen), 32'd0);
        v = '{"after abort", OP_MUL, 32'd9, 32'd9, 32'd81, 34};
        run_op(v, -1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 asserts, fails);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL use one clock, clk_i; reset rst_i is synchronous and active-high.
REQ-002 clk_i  input  1  clock; all state updates on rising edge.
REQ-003 rst_i  input  1  synchronous active-high reset.
REQ-004 start_i  input  1  request an M-extension operation; sampled only in IDLE.
REQ-005 funct3_i  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 a_i  input  32  rs1 operand; b_i  input  32  rs2 operand.
REQ-007 busy_o  output  1  high in CALC, FIX and DONE.
REQ-008 stall_o  output  1  freezes pipeline: (IDLE && start_i) || CALC || FIX.
REQ-009 done_o  output  1  one-cycle pulse, high only in DONE.
REQ-010 result_o  output  32  result; valid when done_o is high, held until the next accepted start.

Function
REQ-011 FSM states SHALL be IDLE, CALC, FIX and DONE; no other states.
REQ-012 IDLE with start_i: latch funct3, operand magnitudes and result sign; load counter with 31; go to CALC. Exception: a divide/remainder with b_i==0 goes straight to DONE.
REQ-013 Signedness: a_i signed for MULH, MULHSU, DIV, REM; b_i signed for MULH, DIV, REM; all other operands unsigned.
REQ-014 CALC: one shift-add (multiply) or one restoring subtract-shift (divide) step per cycle; counter decrements; leave for FIX when counter==0, i.e. after exactly 32 CALC cycles.
REQ-015 FIX: negate the 64-bit product when operand signs differ; negate the quotient when signs differ; give the remainder the sign of the dividend; select low 32 bits for MUL, high 32 bits otherwise; register into result_o; go to DONE.
REQ-016 DONE: done_o=1 for one cycle, then IDLE unconditionally.
REQ-017 Latency: start accepted in cycle 0 -> done_o in cycle 34; divide-by-zero -> done_o in cycle 1.
REQ-018 Divide-by-zero: DIV/DIVU quotient = 0xFFFFFFFF; REM/REMU = a_i unchanged.
REQ-019 Signed overflow (DIV 0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0; no special state.
REQ-020 start_i SHALL be ignored in CALC, FIX and DONE; latched operands unaffected.
REQ-021 a_i, b_i and funct3_i changing after the start cycle SHALL NOT affect the result.
REQ-022 result_o SHALL change only on leaving FIX, on the divide-by-zero fast path and on reset.

Reset
REQ-023 rst_i SHALL force IDLE on the next edge from any state, discarding any in-flight operation.
REQ-024 Values after reset: busy_o=0, done_o=0, stall_o=start_i, result_o=0, counter=0, internal accumulators=0.
REQ-025 When reset and start are both high in the same cycle, reset SHALL take priority and the start SHALL be dropped.

Structure
REQ-026 Shared package muldiv_pkg SHALL hold: the state enum (IDLE, CALC, FIX, DONE), the eight funct3 opcode constants and XLEN=32.
REQ-027 Single module with no sub-module: one registered FSM process, one combinational next-state/step process and one 64-bit accumulator shared by multiply and divide.

Verification
REQ-028 MUL a=7, b=0xFFFFFFFD (-3) -> done_o in cycle 34, result_o=0xFFFFFFEB; stall_o high in cycles 0-33 and low in cycle 34.
REQ-029 MULH a=b=0x80000000 -> 0x40000000; MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
REQ-030 DIV a=-7, b=2 -> 0xFFFFFFFD; REM a=-7, b=2 -> 0xFFFFFFFF; DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
REQ-031 DIVU a=100, b=0 -> 0xFFFFFFFF with done_o in cycle 1; REMU a=100, b=0 -> 100 with done_o in cycle 1.
REQ-032 Start DIVU 100/7, then pulse start_i with new operands in cycle 5 -> the second start is ignored; done_o in cycle 34 with result_o=14.
REQ-033 Start MUL, then assert rst_i in cycle 10 -> IDLE in cycle 11 with busy_o=0 and result_o=0; no done_o pulse; a fresh start then completes normally.
